// File: rtl/nibble_pkg.sv
// nibble_pkg: shared types and widths for the nibble step counter
package nibble_pkg;
  localparam int COUNT_W = 4;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} debounce_state_t;
endpackage

// File: rtl/debounce.sv
// debounce: two-flop synchroniser plus debounce FSM for an active-low push button
module debounce
  import nibble_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] LOAD = DW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic s;
  logic last;
  logic [DW-1:0] dcnt, dcnt_nx;
  debounce_state_t state, state_nx;
  assign s = sync[1];
  assign last = dcnt == DW'(1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= 2'b11;
      state <= IDLE;
      dcnt <= '0;
    end else begin
      sync <= {sync[0], btn_n};
      state <= state_nx;
      dcnt <= dcnt_nx;
    end
  end
  always_comb begin
    state_nx = state;
    dcnt_nx = dcnt;
    unique case (state)
      IDLE: if (!s) begin
        state_nx = PRESS_WAIT;
        dcnt_nx = LOAD;
      end
      PRESS_WAIT: if (s) state_nx = IDLE;
        else if (last) state_nx = HELD;
        else dcnt_nx = dcnt - DW'(1);
      HELD: if (s) begin
        state_nx = RELEASE_WAIT;
        dcnt_nx = LOAD;
      end
      RELEASE_WAIT: if (!s) state_nx = HELD;
        else if (last) state_nx = IDLE;
        else dcnt_nx = dcnt - DW'(1);
    endcase
  end
  // press_pulse is combinational so the count updates on the same edge that enters HELD
  always_comb begin
    pressed = state == HELD || state == RELEASE_WAIT;
    press_pulse = state == PRESS_WAIT && !s && last;
  end
endmodule

// File: rtl/nibble_step_counter.sv
// nibble_step_counter: debounced-press 4-bit counter feeding the LED inverter
// Optional auto-step prescaler enabled by defining AUTO_STEP_EN.
module nibble_step_counter
  import nibble_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PRESCALE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_n,
  input  logic               auto_en,
  output logic [COUNT_W-1:0] count,
  output logic               step,
  output logic               pressed
);
  logic press_pulse;
  logic tick;
  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk(clk),
    .rst_n(rst_n),
    .btn_n(btn_n),
    .pressed(pressed),
    .press_pulse(press_pulse)
  );
`ifdef AUTO_STEP_EN
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0] pcnt;
  assign tick = auto_en && pcnt == PW'(PRESCALE - 1);
  always_ff @(posedge clk) begin
    if (!rst_n || !auto_en) pcnt <= '0;
    else pcnt <= tick ? '0 : pcnt + PW'(1);
  end
`else
  logic unused_auto;
  assign tick = 1'b0;
  assign unused_auto = auto_en | (PRESCALE < 2);
`endif
  // a press and a tick in the same cycle merge into a single increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      step <= 1'b0;
    end else begin
      step <= press_pulse || tick;
      count <= count + COUNT_W'(press_pulse || tick);
    end
  end
endmodule

// File: tb/tb_nibble_step_counter.sv
// tb_nibble_step_counter: randomized scoreboard bench against a run-length debounce model
module tb_nibble_step_counter;
  localparam int D = 4;
  localparam int P = 8;
  logic clk = 0;
  logic rst_n = 0;
  logic btn_n = 1;
  logic auto_en = 0;
  logic [3:0] count;
  logic step;
  logic pressed;
  nibble_step_counter #(.DEBOUNCE_CYCLES(D), .PRESCALE(P)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_n(btn_n),
    .auto_en(auto_en),
    .count(count),
    .step(step),
    .pressed(pressed)
  );
  always #5 clk = ~clk;
  typedef struct {int cyc; logic [3:0] cnt;} exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit hist[$];
  logic lvl = 0;
  int run = 0;
  int en_cnt = 0;
  logic [3:0] mcount = 0;
  // Model: a level flips once D consecutive synchronised samples disagree with it.
  always @(posedge clk) begin
    bit s, manual, tick;
    cyc++;
    if (!rst_n) begin
      hist = '{1'b1, 1'b1};
      lvl = 0;
      run = 0;
      en_cnt = 0;
      mcount = 0;
    end else begin
      s = hist[1];
      hist.push_front(btn_n);
      void'(hist.pop_back());
      manual = 0;
      tick = 0;
      if (s != lvl) run = 0;
      else begin
        run++;
        if (run == D) begin
          lvl = !s;
          run = 0;
          manual = lvl;
        end
      end
`ifdef AUTO_STEP_EN
      if (!auto_en) en_cnt = 0;
      else begin
        en_cnt++;
        if (en_cnt == P) begin
          tick = 1;
          en_cnt = 0;
        end
      end
`endif
      if (manual || tick) begin
        mcount = mcount + 4'd1;
        q.push_back('{cyc, mcount});
      end
    end
  end
  always @(negedge clk) begin
    tests++;
    if (pressed !== lvl) begin
      fails++;
      $display("FAIL pressed cyc=%0d got=%b exp=%b", cyc, pressed, lvl);
    end
    tests++;
    if (count !== mcount) begin
      fails++;
      $display("FAIL count cyc=%0d got=%0d exp=%0d", cyc, count, mcount);
    end
    if (step || (q.size() > 0 && q[0].cyc <= cyc)) begin
      tests++;
      if (step !== 1'b1 || q.size() == 0 || q[0].cyc != cyc || q[0].cnt !== count) begin
        fails++;
        $display("FAIL step cyc=%0d step=%b count=%0d exp_cyc=%0d exp_count=%0d", cyc, step, count,
                 q.size() > 0 ? q[0].cyc : -1, q.size() > 0 ? q[0].cnt : 4'd0);
      end
      if (q.size() > 0 && q[0].cyc <= cyc) void'(q.pop_front());
    end
  end
  task automatic hold(input logic b, input int n);
    btn_n = b;
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_reset();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1;
    hold(1, 3);
    hold(0, 10);
    hold(1, 10);
    hold(0, 2);
    hold(1, 1);
    hold(0, 1);
    hold(1, 1);
    hold(0, 12);
    hold(1, 12);
    for (int i = 0; i < 16; i++) begin
      hold(0, 8);
      hold(1, 8);
    end
    hold(0, 3);
    pulse_reset();
    hold(0, 10);
    hold(1, 10);
    auto_en = 1;
    hold(1, 40);
    hold(0, 10);
    hold(1, 10);
    auto_en = 0;
    hold(1, 5);
    for (int i = 0; i < 300; i++) begin
      auto_en = $urandom_range(0, 3) == 0;
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 9));
      if ($urandom_range(0, 40) == 0) pulse_reset();
    end
    auto_en = 0;
    hold(1, 12);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL leftover pending=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nibble_step_counter.md
# nibble_step_counter

Upstream stage for the 4-bit inverter that drives the board LEDs. Takes the raw active-low push button, synchronises and debounces it, and advances a 4-bit count once per clean press. The count is the inverter's 4-bit input; the inverter output drives the active-low LEDs, so the LEDs show the count. An optional free-running auto-step mode advances the count from a prescaler.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 16: consecutive stable synchronised samples needed to accept a level change. Must be ≥2. Board builds use 270000 (10 ms at 27 MHz).
- PRESCALE, default 8: clock cycles per auto step. Must be ≥2.

Ports:
- clk  in  1  system clock; the block has one clock, all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- btn_n  in  1  raw push button, asynchronous, active-low (0 = pressed).
- auto_en  in  1  auto-step enable; ignored unless AUTO_STEP_EN is defined.
- count  out  4  current count; drives the inverter input.
- step  out  1  one-cycle pulse in the cycle count takes its new value.
- pressed  out  1  debounced button level (1 = held).

## Operation
- Synchroniser: two flops on btn_n, both reset to 1 (released). Call the second flop's output s.
- Debounce FSM (states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) with down-counter dcnt:
  - IDLE: if s==0, go to PRESS_WAIT and load dcnt = DEBOUNCE_CYCLES-1.
  - PRESS_WAIT:
    - s==1: return to IDLE.
    - s==0 and dcnt==1: go to HELD, set pressed=1, fire a manual step.
    - otherwise: decrement dcnt.
  - HELD: if s==1, go to RELEASE_WAIT and load dcnt = DEBOUNCE_CYCLES-1.
  - RELEASE_WAIT:
    - s==0: return to HELD.
    - s==1 and dcnt==1: go to IDLE, set pressed=0.
    - otherwise: decrement dcnt.
  - Any bounce shorter than DEBOUNCE_CYCLES is absorbed. A release produces no step.
- Count: 4-bit, modulo 16. It wraps 15 → 0 with no flag.
- Step event: count ← count+1 and step=1 for exactly one cycle. Otherwise step=0 and count holds.
- A manual step and an auto tick in the same cycle produce one increment (+1, not +2).
- Reset values (next edge with rst_n=0): count=0, step=0, pressed=0, FSM=IDLE, dcnt=0, prescaler=0, synchroniser flops=1.
- Reset mid-press: all state is cleared. A button still held after reset is debounced again as a new press.

## Timing
- btn_n goes low and stays low before edge E0. The synchroniser has s==0 after edge E1.
- PRESS_WAIT is entered at E2. count, step and pressed update at edge E(DEBOUNCE_CYCLES+1).
- Total press-to-count latency: DEBOUNCE_CYCLES+1 edges after btn_n is first sampled.
- Release to pressed=0: same latency.
- step is registered and is high for exactly the cycle after the updating edge.
- count is registered with no combinational path from btn_n.

## Configuration
- Macro AUTO_STEP_EN.
- Defined:
  - A prescaler counts 0..PRESCALE-1 while auto_en=1.
  - When it wraps, a tick produces a step event, so count advances every PRESCALE cycles.
  - auto_en=0 holds the prescaler at 0. Re-enabling gives the first tick PRESCALE cycles later.
  - Manual presses still step in auto mode.
- Undefined: no prescaler logic exists, auto_en is unused, and only debounced presses step the count.

## Structure
- Shared package nibble_pkg:
  - typedef enum logic [1:0] debounce_state_t {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}
  - localparam COUNT_W = 4
- Sub-module debounce:
  - Contains the synchroniser, FSM and dcnt.
  - Ports: clk, rst_n, btn_n; outputs pressed and press_pulse.
  - Parameter: DEBOUNCE_CYCLES.
- The top level holds the count, step merge and optional prescaler. It is instantiated with the inverter downstream in the board top.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, PRESCALE=8, with the inverter connected on count.
- Reset, btn_n=1: count=0, step=0, pressed=0, inverter y=4'hF.
- btn_n held 0 for 10 cycles: count=1 five edges after first low sample; step high exactly one cycle; pressed=1; y=4'hE. Release for 10 cycles: pressed=0, count stays 1.
- Bounce: btn_n low 2 cycles, high 1, low 1, high 1, then low steady: exactly one step; count=1.
- 16 clean presses from reset: count goes 1..15 then 0; 16 step pulses; y=4'hF at the end.
- AUTO_STEP_EN defined, auto_en=1 for 40 cycles with no press: 5 steps spaced 8 cycles apart, count=5. A press coinciding with a tick gives +1 only.
- rst_n=0 for 1 cycle during PRESS_WAIT (dcnt mid-count), btn_n still low: count=0, no step until 5 more edges, then count=1.
